// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory path: access-size encodings, the
// arbiter FSM state type and the default data-memory depth.
package riscv_pkg;

  localparam int unsigned MEM_SIZE = 1024;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Request size field reuses the low bits of the load/store funct3.
  localparam logic [1:0] SIZE_B   = F3_SB[1:0];
  localparam logic [1:0] SIZE_H   = F3_SH[1:0];
  localparam logic [1:0] SIZE_W   = F3_SW[1:0];
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit found
// searching upward from last_grant+1, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last_grant,
  output logic [N_REQ-1:0] grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(last_grant) + off) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between N_REQ requesters;
// one transaction in flight, fixed IDLE -> ISSUE -> RESP occupancy.
module dmem_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MEM_SIZE = riscv_pkg::MEM_SIZE,
  parameter int unsigned N_REQ    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ-1:0]            req_we_i,
  input  logic [2*N_REQ-1:0]          req_size_i,
  input  logic [XLEN*N_REQ-1:0]       req_addr_i,
  input  logic [XLEN*N_REQ-1:0]       req_wdata_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic                        rsp_err_o,
  output logic [XLEN-1:0]             rsp_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr_o,
  output logic [XLEN-1:0]             mem_wdata_o,
  input  logic [XLEN-1:0]             mem_rdata_i
);

  import riscv_pkg::*;

  localparam int unsigned AW   = $clog2(MEM_SIZE);
  localparam int unsigned IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e      state_q;
  logic [IDXW-1:0] last_grant_q;
  logic [IDXW-1:0] owner_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;

  logic [N_REQ-1:0] grant;
  logic [IDXW-1:0]  winner;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic [XLEN-1:0]  sel_addr;
  logic [XLEN-1:0]  sel_wdata;

  logic             req_err;
  logic [3:0]       lane_be;
  logic [XLEN-1:0]  lane_wdata;
  logic [XLEN-1:0]  load_data;
  logic             in_issue;
  logic             in_resp;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_arbiter (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    winner    = '0;
    sel_we    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        winner    = IDXW'(i);
        sel_we    = req_we_i[i];
        sel_size  = req_size_i[2*i +: 2];
        sel_addr  = req_addr_i[XLEN*i +: XLEN];
        sel_wdata = req_wdata_i[XLEN*i +: XLEN];
      end
    end
  end

  // Reset is folded in so a requester already waiting sees no accept while rst_i is high.
  assign req_ready_o = ((state_q == ARB_IDLE) && !rst_i) ? grant : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDXW'(N_REQ - 1);
      owner_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|grant) begin
            owner_q      <= winner;
            last_grant_q <= winner;
            we_q         <= sel_we;
            size_q       <= sel_size;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            state_q      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: state_q <= ARB_RESP;
        ARB_RESP:  state_q <= ARB_IDLE;
        default:   state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    req_err = 1'b0;
    case (size_q)
      SIZE_B:  req_err = 1'b0;
      SIZE_H:  req_err = addr_q[0];
      SIZE_W:  req_err = |addr_q[1:0];
      default: req_err = 1'b1;
    endcase
    if (|addr_q[XLEN-1:AW+2]) req_err = 1'b1;
  end

  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = '0;
    case (size_q)
      SIZE_B: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      SIZE_H: begin
        lane_be    = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      SIZE_W: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = '0;
      end
    endcase
  end

  always_comb begin
    load_data = '0;
    case (size_q)
      SIZE_B:  load_data = XLEN'(mem_rdata_i[{addr_q[1:0], 3'b000} +: 8]);
      SIZE_H:  load_data = XLEN'(mem_rdata_i[{addr_q[1], 4'b0000} +: 16]);
      SIZE_W:  load_data = mem_rdata_i;
      default: load_data = '0;
    endcase
  end

  assign in_issue = (state_q == ARB_ISSUE);
  assign in_resp  = (state_q == ARB_RESP);

  assign mem_req_o   = in_issue && !req_err;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = mem_req_o ? lane_be : 4'b0000;
  assign mem_addr_o  = mem_req_o ? addr_q[AW+1:2] : '0;
  assign mem_wdata_o = mem_req_o ? lane_wdata : '0;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid_o[i] = in_resp && (owner_q == IDXW'(i));
    end
  end

  assign rsp_err_o   = in_resp && req_err;
  assign rsp_rdata_o = (in_resp && !req_err && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a byte-addressed memory model and a round-robin queue model.
module tb_dmem_arbiter;

  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 1024;
  localparam int N_REQ    = 2;
  localparam int AW       = 10;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [N_REQ-1:0]      req_valid_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ-1:0]      req_we_i;
  logic [2*N_REQ-1:0]    req_size_i;
  logic [XLEN*N_REQ-1:0] req_addr_i;
  logic [XLEN*N_REQ-1:0] req_wdata_i;
  logic [N_REQ-1:0]      rsp_valid_o;
  logic                  rsp_err_o;
  logic [XLEN-1:0]       rsp_rdata_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [AW-1:0]         mem_addr_o;
  logic [XLEN-1:0]       mem_wdata_o;
  logic [XLEN-1:0]       mem_rdata_i;

  dmem_arbiter #(
    .XLEN     (XLEN),
    .MEM_SIZE (MEM_SIZE),
    .N_REQ    (N_REQ)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_size_i  (req_size_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tb_mem  [MEM_SIZE];
  logic [7:0]  ref_mem [4*MEM_SIZE];
  int          model_last;

  bit          p_valid [N_REQ];
  bit          p_we    [N_REQ];
  logic [1:0]  p_size  [N_REQ];
  logic [31:0] p_addr  [N_REQ];
  logic [31:0] p_wdata [N_REQ];

  bit watch_r0 = 1'b0;
  bit r0_seen  = 1'b0;

  // Memory responder: applies byte-enabled writes, returns the addressed word one cycle later.
  logic [31:0] resp_word;
  always @(posedge clk) begin
    if (mem_req_o) begin
      resp_word = tb_mem[mem_addr_o];
      mem_rdata_i <= resp_word;
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b] && mem_we_o) resp_word[8*b +: 8] = mem_wdata_o[8*b +: 8];
      tb_mem[mem_addr_o] <= resp_word;
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  always @(req_ready_o) if (watch_r0 && req_ready_o[0]) r0_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid_i[i]            = p_valid[i];
      req_we_i[i]               = p_we[i];
      req_size_i[2*i +: 2]      = p_size[i];
      req_addr_i[XLEN*i +: XLEN]  = p_addr[i];
      req_wdata_i[XLEN*i +: XLEN] = p_wdata[i];
    end
  endtask

  task automatic set_req(input int p, input bit we, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    p_valid[p] = 1'b1; p_we[p] = we; p_size[p] = s; p_addr[p] = a; p_wdata[p] = d;
  endtask

  function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
           ((a >> 2) >= MEM_SIZE);
  endfunction

  // One arbitration slot starting in IDLE; w is the granted port or -1 if nobody asked.
  task automatic run_txn(input int hook, output int w);
    logic [1:0]       s;
    logic [31:0]      a, d, exp_wd, exp_rd;
    logic [3:0]       exp_be;
    logic [N_REQ-1:0] exp_oh;
    bit               we, e;
    int               nb;
    @(negedge clk); drive(); #1;
    w = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = (model_last + k) % N_REQ;
      if (w < 0 && p_valid[c]) w = c;
    end
    exp_oh = '0;
    if (w >= 0) exp_oh[w] = 1'b1;
    checks++;
    if (req_ready_o !== exp_oh) begin failures++; $display("FAIL grant_ready: got %b expected %b", req_ready_o, exp_oh); end
    if (w < 0) return;
    model_last = w;
    s = p_size[w]; a = p_addr[w]; d = p_wdata[w]; we = p_we[w];
    e = is_err(s, a);
    nb = 1 << s;
    exp_be = 4'(((1 << nb) - 1) << (a % 4));
    exp_wd = (s == 2'd0) ? (d & 32'hFF) * 32'h01010101 :
             (s == 2'd1) ? (d & 32'hFFFF) * 32'h00010001 : d;
    exp_rd = '0;

    @(negedge clk);
    p_valid[w] = 1'b0;
    if (hook == 1) set_req(0, 1'b0, 2'd2, 32'h40, 32'h0);
    drive(); #1;
    checks++;
    if (req_ready_o !== '0) begin failures++; $display("FAIL ready_busy: got %b expected 0", req_ready_o); end
    checks++;
    if (mem_req_o !== !e) begin failures++; $display("FAIL mem_req: got %b expected %b", mem_req_o, !e); end
    if (!e) begin
      checks += 4;
      if (mem_we_o !== we) begin failures++; $display("FAIL mem_we: got %b expected %b", mem_we_o, we); end
      if (mem_be_o !== exp_be) begin failures++; $display("FAIL mem_be: got %b expected %b", mem_be_o, exp_be); end
      if (mem_addr_o !== AW'(a >> 2)) begin failures++; $display("FAIL mem_addr: got %0h expected %0h", mem_addr_o, a >> 2); end
      if (mem_wdata_o !== exp_wd) begin failures++; $display("FAIL mem_wdata: got %h expected %h", mem_wdata_o, exp_wd); end
      for (int k = 0; k < nb; k++) begin
        if (we) ref_mem[a + k] = d[8*k +: 8];
        else    exp_rd[8*k +: 8] = ref_mem[a + k];
      end
    end

    @(negedge clk);
    if (hook == 1) begin p_valid[0] = 1'b0; drive(); end
    #1;
    checks += 3;
    if (rsp_valid_o !== exp_oh) begin failures++; $display("FAIL rsp_valid: got %b expected %b", rsp_valid_o, exp_oh); end
    if (rsp_err_o !== e) begin failures++; $display("FAIL rsp_err: got %b expected %b", rsp_err_o, e); end
    if (rsp_rdata_o !== exp_rd) begin failures++; $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata_o, exp_rd); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < N_REQ; i++) p_valid[i] = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_last = N_REQ - 1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 2'd2, 32'h0, 32'h0);
    drive();
    #2 rst_i = 1'b1;
    #1;
    checks += 3;
    if (req_ready_o !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
    if (rsp_valid_o !== '0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== '0) begin
      failures++; $display("FAIL reset_rsp: got %b/%b/%h expected 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== '0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      failures++; $display("FAIL reset_mem: got req=%b we=%b be=%b expected 0", mem_req_o, mem_we_o, mem_be_o);
    end
    do_reset();
  endtask

  task automatic test_word();
    int w;
    set_req(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    run_txn(0, w);
    set_req(0, 1'b0, 2'd2, 32'h10, 32'h0);
    run_txn(0, w);
    checks++;
    if (rsp_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h expected deadbeef", rsp_rdata_o); end
  endtask

  task automatic test_byte();
    int w;
    set_req(0, 1'b1, 2'd2, 32'h10, 32'h0);
    run_txn(0, w);
    set_req(0, 1'b1, 2'd0, 32'h13, 32'h123456A5);
    run_txn(0, w);
    checks++;
    if (tb_mem[4] !== 32'hA5000000) begin failures++; $display("FAIL sb_word: got %h expected a5000000", tb_mem[4]); end
    set_req(0, 1'b0, 2'd0, 32'h13, 32'h0);
    run_txn(0, w);
    checks++;
    if (rsp_rdata_o !== 32'h000000A5) begin failures++; $display("FAIL lb_data: got %h expected 000000a5", rsp_rdata_o); end
    set_req(0, 1'b1, 2'd1, 32'h22, 32'h0000BEEF);
    run_txn(0, w);
    set_req(0, 1'b0, 2'd1, 32'h22, 32'h0);
    run_txn(0, w);
  endtask

  task automatic test_errors();
    int w;
    set_req(1, 1'b0, 2'd1, 32'h21, 32'h0);
    run_txn(0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL err_owner: got %0d expected 1", w); end
    set_req(1, 1'b0, 2'd2, 32'h1000, 32'h0);
    run_txn(0, w);
    set_req(1, 1'b1, 2'd2, 32'h1010, 32'hFFFFFFFF);
    run_txn(0, w);
    set_req(1, 1'b1, 2'd3, 32'h10, 32'hFFFFFFFF);
    run_txn(0, w);
    set_req(1, 1'b1, 2'd0, 32'hFFF, 32'h5A);
    run_txn(0, w);
    set_req(1, 1'b0, 2'd0, 32'hFFF, 32'h0);
    run_txn(0, w);
    set_req(1, 1'b0, 2'd2, 32'h10, 32'h0);
    run_txn(0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    int exp_seq [4] = '{0, 1, 0, 1};
    do_reset();
    set_req(0, 1'b0, 2'd2, 32'h10, 32'h0);
    set_req(1, 1'b0, 2'd2, 32'h20, 32'h0);
    for (int t = 0; t < 4; t++) begin
      run_txn(0, w);
      checks++;
      if (w != exp_seq[t]) begin failures++; $display("FAIL rr_order: got %0d expected %0d", w, exp_seq[t]); end
      if (w >= 0) p_valid[w] = 1'b1;
    end
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    set_req(0, 1'b0, 2'd2, 32'h10, 32'h0);
    @(negedge clk); drive(); #1;
    checks++;
    if (req_ready_o !== 2'b01) begin failures++; $display("FAIL mid_grant: got %b expected 01", req_ready_o); end
    @(negedge clk);
    p_valid[0] = 1'b0;
    set_req(1, 1'b0, 2'd2, 32'h20, 32'h0);
    drive();
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || rsp_valid_o !== '0 || req_ready_o !== '0 || mem_be_o !== '0) begin
      failures++; $display("FAIL mid_async: got req=%b rsp=%b rdy=%b expected 0", mem_req_o, rsp_valid_o, req_ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== '0) begin failures++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid_o); end
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_last = N_REQ - 1;
    run_txn(0, w);
    checks++;
    if (w != 1) begin failures++; $display("FAIL mid_first: got %0d expected 1", w); end
  endtask

  task automatic test_drop();
    int w;
    watch_r0 = 1'b1;
    r0_seen  = 1'b0;
    set_req(1, 1'b0, 2'd2, 32'h24, 32'h0);
    run_txn(1, w);
    set_req(1, 1'b0, 2'd2, 32'h28, 32'h0);
    run_txn(0, w);
    watch_r0 = 1'b0;
    checks += 2;
    if (w != 1) begin failures++; $display("FAIL drop_grant: got %0d expected 1", w); end
    if (r0_seen) begin failures++; $display("FAIL drop_ready0: got 1 expected 0"); end
  endtask

  task automatic gen(input int p);
    logic [1:0]  s;
    logic [31:0] a;
    s = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
    a = $urandom % 64;
    a = a & ~((32'd1 << s) - 1);
    if ($urandom % 8 == 0) a = a + ($urandom % 4);
    if ($urandom % 16 == 0) a = a | (32'h1000 << ($urandom % 20));
    set_req(p, bit'($urandom % 2), s, a, $urandom);
  endtask

  task automatic test_random();
    int w;
    for (int t = 0; t < 120; t++) begin
      run_txn(0, w);
      if (w >= 0 && ($urandom % 4 != 0)) gen(w);
      for (int c = 0; c < N_REQ; c++)
        if (!p_valid[c] && ($urandom % 2 == 0)) gen(c);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) begin
      tb_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tb_mem[i][8*b +: 8];
    end
    for (int i = 0; i < N_REQ; i++) begin
      p_valid[i] = 1'b0; p_we[i] = 1'b0; p_size[i] = '0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    rst_i = 1'b0;
    drive();
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between N_REQ requesters: core load/store unit on port 0, debug/loader on port 1. Round-robin arbitration, one transaction in flight at a time. Converts byte addresses plus size (SB/SH/SW widths) into word address, byte enables and lane-replicated write data. Returns right-justified load data and a completion/error pulse to the winning requester.

Parameters:
XLEN, 32, data/address width
MEM_SIZE, 1024, memory depth in 32-bit words; power of two
N_REQ, 2, number of requesters; 2..4

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  N_REQ  request valid, one bit per requester
req_ready_o  out  N_REQ  request accepted this cycle (one-hot or zero)
req_we_i  in  N_REQ  1 = store, 0 = load
req_size_i  in  2*N_REQ  per requester: 00 byte, 01 half, 10 word, 11 illegal
req_addr_i  in  XLEN*N_REQ  per-requester byte address
req_wdata_i  in  XLEN*N_REQ  per-requester store data, right-justified
rsp_valid_o  out  N_REQ  one-cycle completion pulse to the owning requester
rsp_err_o  out  1  qualifies rsp_valid_o: misaligned, illegal size or out of range
rsp_rdata_o  out  XLEN  load data, right-justified, zero-extended; 0 on store or error
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write
mem_be_o  out  4  byte enables
mem_addr_o  out  $clog2(MEM_SIZE)  word index
mem_wdata_o  out  XLEN  lane-replicated write data
mem_rdata_i  in  XLEN  read word, valid the cycle after mem_req_o

Behaviour:
- Reset: FSM IDLE; every output 0; rr pointer last_grant = N_REQ-1, so requester 0 wins first.
- FSM IDLE -> ISSUE -> RESP -> IDLE. Fixed 3-cycle occupancy per transaction.
- IDLE:
  - Winner = first valid requester searching from last_grant+1 modulo N_REQ.
  - req_ready_o[winner] = 1 combinationally in the same cycle.
  - Register we, size, addr, wdata and owner; last_grant <= winner; go to ISSUE.
  - No valid requester: stay in IDLE, ready all 0.
- ISSUE:
  - Legal request: mem_req_o = 1 for exactly one cycle, with mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o from the registered request.
  - Illegal request: no mem_req_o.
  - Go to RESP.
- RESP:
  - rsp_valid_o[owner] = 1 for one cycle.
  - Load: lane extracted from mem_rdata_i. Byte: rdata[7:0] = lane a[1:0]. Half: rdata[15:0] = half a[1]. Upper bits 0.
  - Store: pulse is a write acknowledgement, rdata 0.
  - Go to IDLE; a new grant is possible the following cycle.
- Address/lane rules:
  - word index = addr[$clog2(MEM_SIZE)+1:2].
  - be: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111.
  - wdata: byte replicated x4, half replicated x2, word as-is.
- Error when any of:
  - size 11;
  - half with a[0] = 1;
  - word with a[1:0] != 0;
  - addr >> 2 >= MEM_SIZE.
  - On error: rsp_err_o = 1 with the pulse, rdata 0, memory untouched.
- Ready is never asserted outside IDLE; requesters hold valid and payload until ready.
- A requester that drops valid before being granted is simply skipped.
- Simultaneous requests alternate strictly under round-robin. No requester waits more than N_REQ transactions.
- Reset mid-transaction abandons it. No rsp_valid_o is issued. If reset hits in ISSUE, the write is not guaranteed.

Decomposition:
- Shared package (riscv_pkg): size encodings aligned with F3_SB/F3_SH/F3_SW low bits, an arb_state_e enum (IDLE, ISSUE, RESP), and MEM_SIZE.
- One sub-module: rr_arbiter. Inputs: N_REQ-bit request, last_grant. Output: one-hot grant. Purely combinational, reusable.
- Lane/byte-enable logic stays inline.

Test Plan:
- Port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_addr_o = 4, be = 1111; rsp_rdata_o = 0xDEADBEEF on the 3rd cycle after grant.
- Port0 SB addr 0x13 data 0xA5 -> be = 1000, mem_wdata_o = 0xA5A5A5A5. Following LB 0x13 with mem word 0xA5000000 -> rdata = 0x000000A5.
- Port0 and port1 both hold valid for 4 transactions after reset -> grants 0,1,0,1. Each rsp_valid_o goes only to the owning port.
- Port1 LH addr 0x21 -> no mem_req_o; rsp_valid_o[1] with rsp_err_o = 1, rdata 0. Same for LW addr 0x1000 (MEM_SIZE = 1024).
- rst_i asserted during ISSUE of a port0 load -> all outputs 0 asynchronously, no rsp_valid_o. After release, port1-only request granted first cycle in IDLE.
- Port0 valid deasserted before grant while port1 valid -> port1 granted; req_ready_o[0] never high.
